uni_shift_reg: RTL and testbench
================================

# uni_shift_reg

Parametrised universal shift register supporting serial-in/serial-out, serial-in/parallel-out (deserialiser), parallel-in/serial-out (serialiser) and parallel-in/parallel-out modes. It has a shift-enable strobe, a valid/ready load handshake and a word-complete strobe. It is the general-purpose successor to the fixed 4-bit SISO register and serves as the serial link endpoint and bit-stream buffer across the design.

## Interface
- WIDTH, 8, register width in bits; must be ≥ 2.
- MSB_FIRST, 1, 1: shift toward MSB, sdo = buffer[WIDTH-1]; 0: shift toward LSB, sdo = buffer[0].
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  00 SISO, 01 SIPO, 10 PISO, 11 PIPO; quasi-static.
- en  in  1  shift enable; one bit moves per clk edge with en=1.
- sdi  in  1  serial data in.
- sdo  out  1  serial data out, combinational from the buffer end bit.
- pdi  in  WIDTH  parallel load data.
- pdi_valid  in  1  load request.
- pdi_ready  out  1  load accept, combinational.
- pdo  out  WIDTH  registered parallel output word.
- pdo_valid  out  1  one-cycle strobe: a new word is on pdo.

## Operation
- Internal state:
  - buffer[WIDTH-1:0]
  - cnt, width $clog2(WIDTH+1)
  - mode_q (registered mode)
  - pdo register
  - pdo_valid register
- Mode change: when mode != mode_q on an edge:
  - mode_q <= mode and cnt <= 0.
  - No shift or load occurs; pdo_valid <= 0; pdi_ready = 0 that cycle.
  - buffer and pdo are retained.
- Shift: on en=1, buffer <= {buffer[WIDTH-2:0], in} when MSB_FIRST=1, else {in, buffer[WIDTH-1:1]}.
  - In SISO and SIPO, in = sdi.
  - In PISO, in = 0.
  - In PIPO, en is ignored.
- SISO:
  - Pure delay line; cnt unused.
  - pdi_ready = 0, pdo_valid = 0.
- SIPO:
  - Each en edge increments cnt.
  - On the en edge where cnt == WIDTH-1: pdo <= next buffer value, pdo_valid <= 1, cnt <= 0.
  - The first bit received lands at pdo[WIDTH-1] when MSB_FIRST=1.
  - pdi_ready = 0.
- PISO:
  - pdi_ready = (cnt == 0) || (cnt == 1 && en).
  - Load on pdi_valid && pdi_ready: buffer <= pdi, cnt <= WIDTH. Load takes priority over the shift in the same cycle.
  - Each en edge with cnt > 0 shifts once and decrements cnt.
  - When cnt == 0, en has no effect.
  - pdo_valid = 0.
- PIPO:
  - pdi_ready = 1.
  - On pdi_valid: buffer <= pdi, pdo <= pdi, pdo_valid <= 1.
- pdo_valid is otherwise cleared every cycle; it is never high for two consecutive cycles unless back-to-back words complete.

## Timing
- Reset (async assert, sync-deasserted upstream):
  - buffer, cnt, pdo and pdo_valid all 0.
  - mode_q = 00; sdo = 0.
  - pdi_ready = 0 unless mode_q == mode and mode ∈ {PISO, PIPO}.
- Reset mid-operation aborts the word; no partial pdo_valid.
- SISO latency: an sdi bit sampled at en-edge k appears on sdo after en-edge k+WIDTH-1. This is WIDTH en-edges of delay, matching the 4-bit predecessor for WIDTH=4.
- SIPO: pdo and pdo_valid are visible the cycle after the WIDTH-th en edge. Gaps in en stretch the word without loss.
- PISO:
  - First bit on sdo the cycle after the load edge.
  - Each subsequent en edge presents the next bit.
  - With en held high, back-to-back words stream gap-free: the reload occurs on the edge that shifts out the last bit.
- PIPO: pdo_valid the cycle after the load edge.
- Mode change: the first cycle in the new mode is the flush cycle; normal operation starts on the next edge.

## Structure
- Package uni_shift_pkg:
  - typedef enum logic [1:0] shift_mode_e {SISO, SIPO, PISO, PIPO}
  - Helper constant function cnt_width(WIDTH).
- Sub-module uni_shift_bitcnt:
  - Loadable up/down bit counter with clear, wrap-at-terminal and terminal-count flag.
  - Shared by SIPO (count-up) and PISO (count-down).
- Top level holds the buffer, mode_q, handshake decode and pdo register.

## Test plan
All scenarios use WIDTH=8, MSB_FIRST=1.
- SISO, en=1, sdi = 1 then 0s:
  - sdo = 1 exactly once, on the cycle after the 8th edge (7 edges after the 1 was sampled).
  - en=0 cycles freeze sdo.
- SIPO, shift 0xA5 MSB-first with en dropping for 2 cycles mid-word:
  - pdo = 0xA5 and a single pdo_valid pulse the cycle after the 8th en edge.
  - A second word 0x3C follows with no gap.
- PISO, load 0x3C then hold en=1:
  - sdo = 0,0,1,1,1,1,0,0.
  - pdi_ready low for 7 cycles, high on the last-bit cycle.
  - A queued 0xFF loads with no idle bit; sdo = eight 1s.
- PIPO, pdi = 0x5A, pdi_valid for 1 cycle → pdo = 0x5A and a one-cycle pdo_valid on the next cycle.
- PISO 0xF0, switch mode to SIPO after 3 bits:
  - One flush cycle with pdi_ready = 0 and no pdo_valid.
  - The following 8 sdi bits yield exactly one correct pdo word.
- SIPO after 5 bits, assert reset_n = 0 mid-cycle:
  - pdo, buffer, sdo and pdo_valid go to 0 immediately.
  - After release, a full 0x81 is captured correctly.

Source files
------------

// File: rtl/uni_shift_pkg.sv
// Shared types and sizing helpers for the universal shift register.
package uni_shift_pkg;

    typedef enum logic [1:0] {
        SISO = 2'b00,
        SIPO = 2'b01,
        PISO = 2'b10,
        PIPO = 2'b11
    } shift_mode_e;

    // Counter must hold the value WIDTH itself (PISO preload), hence +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/uni_shift_bitcnt.sv
// Loadable up/down bit counter: wraps to zero after WIDTH-1 when counting up,
// stops at zero when counting down.
module uni_shift_bitcnt
    import uni_shift_pkg::*;
#(
    parameter int   WIDTH = 8,
    localparam int  CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc,
    output logic          o_zero
);

    localparam logic [CW-1:0] TERM = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the always blocks execute in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + CW'(1);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tc   = (r_cnt == TERM);
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/uni_shift_reg.sv
// Universal shift register: SISO delay line, SIPO deserialiser, PISO serialiser
// and PIPO word register, with a valid/ready load port and word-complete strobe.
module uni_shift_reg
    import uni_shift_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    localparam int  CW        = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       i_mode,
    input  logic             i_en,
    input  logic             i_sdi,
    output logic             o_sdo,
    input  logic [WIDTH-1:0] i_pdi,
    input  logic             i_pdi_valid,
    output logic             o_pdi_ready,
    output logic [WIDTH-1:0] o_pdo,
    output logic             o_pdo_valid
);

    shift_mode_e      r_mode_q;
    logic [WIDTH-1:0] r_buf;
    logic [WIDTH-1:0] r_pdo;
    logic             r_pdo_valid;

    shift_mode_e      w_mode;
    logic             w_mode_chg;
    logic             w_shift_in;
    logic [WIDTH-1:0] w_shifted;
    logic             w_pdi_ready;
    logic             w_load;
    logic             w_shift;
    logic             w_word_done;
    logic             w_cnt_clr;
    logic             w_cnt_load;
    logic             w_cnt_inc;
    logic             w_cnt_dec;
    logic [CW-1:0]    w_cnt;
    logic             w_cnt_tc;
    logic             w_cnt_zero;

    assign w_mode     = shift_mode_e'(i_mode);
    assign w_mode_chg = (w_mode != r_mode_q);
    assign w_shift_in = ((r_mode_q == SISO) || (r_mode_q == SIPO)) ? i_sdi : 1'b0;

    always_comb begin
        if (MSB_FIRST) begin
            w_shifted = {r_buf[WIDTH-2:0], w_shift_in};
        end else begin
            w_shifted = {w_shift_in, r_buf[WIDTH-1:1]};
        end
    end

    // One counter serves both directions: SIPO counts received bits up and
    // wraps at the word boundary, PISO counts remaining bits down.
    uni_shift_bitcnt #(
        .WIDTH      (WIDTH)
    ) u_bitcnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (CW'(WIDTH)),
        .i_inc      (w_cnt_inc),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_tc       (w_cnt_tc),
        .o_zero     (w_cnt_zero)
    );

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_pdi_ready = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_word_done = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_dec   = 1'b0;
        if (w_mode_chg) begin
            // Flush cycle: only the mode register and counter move.
            w_cnt_clr = 1'b1;
        end else begin
            case (r_mode_q)
                SISO: begin
                    w_shift = i_en;
                end
                SIPO: begin
                    w_shift     = i_en;
                    w_cnt_inc   = i_en;
                    w_word_done = i_en && w_cnt_tc;
                end
                PISO: begin
                    // Ready on the last-bit edge too, so words stream gap-free.
                    w_pdi_ready = w_cnt_zero || ((w_cnt == CW'(1)) && i_en);
                    w_load      = i_pdi_valid && w_pdi_ready;
                    w_cnt_load  = w_load;
                    w_shift     = !w_load && i_en && !w_cnt_zero;
                    w_cnt_dec   = w_shift;
                end
                PIPO: begin
                    w_pdi_ready = 1'b1;
                    w_load      = i_pdi_valid;
                    w_word_done = i_pdi_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_q    <= SISO;
            r_buf       <= '0;
            r_pdo       <= '0;
            r_pdo_valid <= 1'b0;
        end else begin
            r_pdo_valid <= w_word_done;
            if (w_mode_chg) begin
                r_mode_q <= w_mode;
            end
            if (w_load) begin
                r_buf <= i_pdi;
            end else if (w_shift) begin
                r_buf <= w_shifted;
            end
            if (w_word_done) begin
                r_pdo <= (r_mode_q == PIPO) ? i_pdi : w_shifted;
            end
        end
    end

    assign o_sdo       = MSB_FIRST ? r_buf[WIDTH-1] : r_buf[0];
    assign o_pdi_ready = w_pdi_ready;
    assign o_pdo       = r_pdo;
    assign o_pdo_valid = r_pdo_valid;

endmodule

// File: tb/tb_uni_shift_reg.sv
// Bench for uni_shift_reg (WIDTH=8, MSB first): word-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_uni_shift_reg;
    import uni_shift_pkg::*;

    localparam int WIDTH = 8;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic [1:0] mode      = 2'b00;
    logic       en        = 1'b0;
    logic       sdi       = 1'b0;
    logic [7:0] pdi       = 8'h00;
    logic       pdi_valid = 1'b0;
    logic       sdo;
    logic       pdi_ready;
    logic [7:0] pdo;
    logic       pdo_valid;

    int checks   = 0;
    int failures = 0;

    uni_shift_reg #(
        .WIDTH      (WIDTH),
        .MSB_FIRST  (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_mode      (mode),
        .i_en        (en),
        .i_sdi       (sdi),
        .o_sdo       (sdo),
        .i_pdi       (pdi),
        .i_pdi_valid (pdi_valid),
        .o_pdi_ready (pdi_ready),
        .o_pdo       (pdo),
        .o_pdo_valid (pdo_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the register as a number, plus "bits received" and
    // "bits still to send" counts.
    typedef struct {
        logic [7:0] word;
        logic [7:0] pdo;
        logic       pv;
        int         mode;
        int         rx;
        int         left;
    } model_t;

    model_t m;

    function automatic logic [7:0] shl(input logic [7:0] w, input logic b);
        return 8'((int'(w) * 2 + int'(b)) % 256);
    endfunction

    function automatic logic model_ready(input model_t s);
        if (int'(mode) != s.mode) return 1'b0;
        if (s.mode == int'(PIPO)) return 1'b1;
        if (s.mode == int'(PISO)) return (s.left == 0) || (s.left == 1 && en);
        return 1'b0;
    endfunction

    function automatic model_t model_next(input model_t s);
        model_t n   = s;
        logic   rdy = model_ready(s);
        n.pv = 1'b0;
        if (int'(mode) != s.mode) begin
            n.mode = int'(mode);
            n.rx   = 0;
            n.left = 0;
        end else if (s.mode == int'(SISO)) begin
            if (en) n.word = shl(s.word, sdi);
        end else if (s.mode == int'(SIPO)) begin
            if (en) begin
                n.word = shl(s.word, sdi);
                n.rx   = s.rx + 1;
                if (n.rx == WIDTH) begin
                    n.pdo = n.word;
                    n.pv  = 1'b1;
                    n.rx  = 0;
                end
            end
        end else if (s.mode == int'(PISO)) begin
            if (pdi_valid && rdy) begin
                n.word = pdi;
                n.left = WIDTH;
            end else if (en && s.left > 0) begin
                n.word = shl(s.word, 1'b0);
                n.left = s.left - 1;
            end
        end else begin
            if (pdi_valid) begin
                n.word = pdi;
                n.pdo  = pdi;
                n.pv   = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= '{word: 8'h00, pdo: 8'h00, pv: 1'b0, mode: 0, rx: 0, left: 0};
        end else begin
            m <= model_next(m);
        end
    end

    // Inputs change at negedge+1; outputs (incl. combinational ready) are checked at negedge+3.
    always begin
        @(negedge clk);
        #3;
        check("model_sdo", 32'(sdo), 32'(m.word[7]));
        check("model_pdi_ready", 32'(pdi_ready), 32'(model_ready(m)));
        check("model_pdo", 32'(pdo), 32'(m.pdo));
        check("model_pdo_valid", 32'(pdo_valid), 32'(m.pv));
    end

    logic rdy_seen;

    task automatic step(input logic [1:0] md, input logic e, input logic s,
                        input logic [7:0] d, input logic v);
        @(negedge clk);
        #1;
        mode      = md;
        en        = e;
        sdi       = s;
        pdi       = d;
        pdi_valid = v;
        #1 rdy_seen = pdi_ready;
        @(posedge clk);
        #1;
    endtask

    logic [10:0] siso_obs;
    logic [15:0] stream;
    logic [7:0]  rdy_vec;
    logic [7:0]  w;
    int          pulses;

    initial begin
        // Reset state
        #2;
        check("rst_sdo", 32'(sdo), 32'h0);
        check("rst_pdo", 32'(pdo), 32'h0);
        check("rst_pdo_valid", 32'(pdo_valid), 32'h0);
        check("rst_pdi_ready", 32'(pdi_ready), 32'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // SISO: single 1 through an 8-deep delay line, then freeze with en=0
        step(SISO, 1'b1, 1'b1, 8'h00, 1'b0);
        siso_obs[0] = sdo;
        for (int i = 1; i < 8; i++) begin
            step(SISO, 1'b1, 1'b0, 8'h00, 1'b0);
            siso_obs[i] = sdo;
        end
        step(SISO, 1'b0, 1'b0, 8'h00, 1'b0);
        siso_obs[8] = sdo;
        step(SISO, 1'b0, 1'b0, 8'h00, 1'b0);
        siso_obs[9] = sdo;
        step(SISO, 1'b1, 1'b0, 8'h00, 1'b0);
        siso_obs[10] = sdo;
        check("siso_sdo_seq", 32'(siso_obs), 32'(11'b01110000000));

        // SIPO: 0xA5 with a 2-cycle en gap, then 0x3C back-to-back
        step(SIPO, 1'b0, 1'b0, 8'h00, 1'b0);
        check("sipo_flush_valid", 32'(pdo_valid), 32'h0);
        pulses = 0;
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                repeat (2) begin
                    step(SIPO, 1'b0, 1'b1, 8'h00, 1'b0);
                    if (pdo_valid) pulses++;
                end
            end
            step(SIPO, 1'b1, w[7-i], 8'h00, 1'b0);
            if (pdo_valid) pulses++;
        end
        check("sipo_pdo_a5", 32'(pdo), 32'hA5);
        check("sipo_valid_a5", 32'(pdo_valid), 32'h1);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            step(SIPO, 1'b1, w[7-i], 8'h00, 1'b0);
            if (pdo_valid) pulses++;
            if (i == 0) check("sipo_single_pulse", 32'(pdo_valid), 32'h0);
        end
        check("sipo_pdo_3c", 32'(pdo), 32'h3C);
        check("sipo_valid_3c", 32'(pdo_valid), 32'h1);
        check("sipo_pulse_count", 32'(pulses), 32'd2);

        // PISO: 0x3C then queued 0xFF streamed with en held high
        step(PISO, 1'b0, 1'b0, 8'h00, 1'b0);
        check("piso_flush_ready", 32'(rdy_seen), 32'h0);
        step(PISO, 1'b1, 1'b0, 8'h3C, 1'b1);
        check("piso_load_ready", 32'(rdy_seen), 32'h1);
        stream  = {15'h0, sdo};
        rdy_vec = 8'h00;
        for (int s = 1; s < 16; s++) begin
            step(PISO, 1'b1, 1'b0, 8'hFF, (s <= 8));
            stream = {stream[14:0], sdo};
            if (s <= 8) rdy_vec = {rdy_vec[6:0], rdy_seen};
        end
        check("piso_stream", 32'(stream), 32'h3CFF);
        check("piso_ready_pattern", 32'(rdy_vec), 32'h01);
        step(PISO, 1'b1, 1'b0, 8'h00, 1'b0);
        check("piso_last_ready", 32'(rdy_seen), 32'h1);
        check("piso_drained_sdo", 32'(sdo), 32'h0);

        // PIPO
        step(PIPO, 1'b0, 1'b0, 8'h00, 1'b0);
        step(PIPO, 1'b0, 1'b0, 8'h5A, 1'b1);
        check("pipo_ready", 32'(rdy_seen), 32'h1);
        check("pipo_pdo", 32'(pdo), 32'h5A);
        check("pipo_valid", 32'(pdo_valid), 32'h1);
        step(PIPO, 1'b0, 1'b0, 8'h00, 1'b0);
        check("pipo_valid_drop", 32'(pdo_valid), 32'h0);
        check("pipo_pdo_hold", 32'(pdo), 32'h5A);

        // PISO 0xF0 interrupted after 3 bits by a switch to SIPO
        step(PISO, 1'b0, 1'b0, 8'h00, 1'b0);
        step(PISO, 1'b1, 1'b0, 8'hF0, 1'b1);
        check("switch_first_bit", 32'(sdo), 32'h1);
        repeat (3) step(PISO, 1'b1, 1'b0, 8'h00, 1'b0);
        step(SIPO, 1'b1, 1'b1, 8'h00, 1'b0);
        check("switch_flush_ready", 32'(rdy_seen), 32'h0);
        check("switch_flush_valid", 32'(pdo_valid), 32'h0);
        pulses = 0;
        w = 8'h96;
        for (int i = 0; i < 8; i++) begin
            step(SIPO, 1'b1, w[7-i], 8'h00, 1'b0);
            if (pdo_valid) pulses++;
        end
        check("switch_pdo", 32'(pdo), 32'h96);
        check("switch_pulse_count", 32'(pulses), 32'd1);

        // Async reset after 5 SIPO bits, then capture 0x81
        w = 8'b11001000;
        for (int i = 0; i < 5; i++) step(SIPO, 1'b1, w[7-i], 8'h00, 1'b0);
        check("pre_reset_sdo", 32'(sdo), 32'h1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_pdo", 32'(pdo), 32'h0);
        check("midrst_sdo", 32'(sdo), 32'h0);
        check("midrst_valid", 32'(pdo_valid), 32'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        step(SIPO, 1'b0, 1'b0, 8'h00, 1'b0);
        pulses = 0;
        w = 8'h81;
        for (int i = 0; i < 8; i++) begin
            step(SIPO, 1'b1, w[7-i], 8'h00, 1'b0);
            if (pdo_valid) pulses++;
        end
        check("postrst_pdo", 32'(pdo), 32'h81);
        check("postrst_valid", 32'(pdo_valid), 32'h1);
        check("postrst_pulse_count", 32'(pulses), 32'd1);

        step(SIPO, 1'b0, 1'b0, 8'h00, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
